// File: rtl/div_seq.sv
// ============================================================================
//  Module : div_seq
//  Multi-cycle restoring divider (one quotient bit per clock) with a
//  start/busy/done handshake. Optional signed mode enabled by DIV_SIGNED_EN.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module div_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
`ifdef DIV_SIGNED_EN
    input  logic             sgn,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div0
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;
    localparam int         CW     = $clog2(WIDTH + 1);

    logic [1:0]       r_state;
    logic [1:0]       w_next;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_dvs;
    logic             r_zero;
    logic             r_neg_q;
    logic             r_neg_r;

    logic             w_sgn;
    logic             w_accept;
    logic             w_last;
    logic             w_dvd_neg;
    logic             w_dvs_neg;
    logic [WIDTH-1:0] w_dvd_mag;
    logic [WIDTH-1:0] w_dvs_mag;
    logic [WIDTH:0]   w_shift;
    logic [WIDTH:0]   w_trial;
    logic [WIDTH-1:0] w_q_next;
    logic [WIDTH-1:0] w_rem_next;

`ifdef DIV_SIGNED_EN
    assign w_sgn = sgn;
`else
    assign w_sgn = 1'b0;
`endif

    assign w_accept  = start && (r_state != S_RUN);
    assign w_last    = (r_cnt == CW'(1));
    assign w_dvd_neg = w_sgn & dividend[WIDTH-1];
    assign w_dvs_neg = w_sgn & divisor[WIDTH-1];
    assign w_dvd_mag = w_dvd_neg ? (~dividend + 1'b1) : dividend;
    assign w_dvs_mag = w_dvs_neg ? (~divisor + 1'b1) : divisor;

    // Trial difference stays within +/-2^WIDTH, so its MSB is a valid sign bit.
    assign w_shift    = {r_rem, r_q[WIDTH-1]};
    assign w_trial    = w_shift - {1'b0, r_dvs};
    assign w_q_next   = {r_q[WIDTH-2:0], ~w_trial[WIDTH]};
    assign w_rem_next = w_trial[WIDTH] ? w_shift[WIDTH-1:0] : w_trial[WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = S_RUN;
            S_RUN:   if (w_last) w_next = S_DONE;
            S_DONE:  w_next = start ? S_RUN : S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (r_state == S_RUN);
        done = (r_state == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt     <= '0;
            r_q       <= '0;
            r_rem     <= '0;
            r_dvs     <= '0;
            r_zero    <= 1'b0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            div0      <= 1'b0;
        end else if (w_accept) begin
            // A zero divisor keeps the raw dividend so it can be returned as-is.
            r_q     <= (divisor == '0) ? dividend : w_dvd_mag;
            r_rem   <= '0;
            r_dvs   <= w_dvs_mag;
            r_zero  <= (divisor == '0);
            r_cnt   <= (divisor == '0) ? CW'(1) : CW'(WIDTH);
            r_neg_q <= w_dvd_neg ^ w_dvs_neg;
            r_neg_r <= w_dvd_neg;
            if (divisor != '0) begin
                div0 <= 1'b0;
            end
        end else if (r_state == S_RUN) begin
            r_q   <= w_q_next;
            r_rem <= w_rem_next;
            r_cnt <= r_cnt - CW'(1);
            if (w_last) begin
                if (r_zero) begin
                    quotient  <= '1;
                    remainder <= r_q;
                    div0      <= 1'b1;
                end else begin
                    quotient  <= r_neg_q ? (~w_q_next + 1'b1) : w_q_next;
                    remainder <= r_neg_r ? (~w_rem_next + 1'b1) : w_rem_next;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_div_seq.sv
// Self-checking bench for div_seq: directed handshake cases plus randomized
// operands compared against an arithmetic reference model.
`default_nettype none

module tb_div_seq;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         sgn = 1'b0;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div0;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    div_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
`ifdef DIV_SIGNED_EN
        .sgn       (sgn),
`endif
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .div0      (div0)
    );

    function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                                  output logic [W-1:0] q, output logic [W-1:0] r);
        int sa, sb, sq, sr;
        if (b == '0) begin
            q = '1;
            r = a;
        end else if (s) begin
            sa = int'($signed(a));
            sb = int'($signed(b));
            sq = sa / sb;
            sr = sa % sb;
            q  = sq[W-1:0];
            r  = sr[W-1:0];
        end else begin
            q = a / b;
            r = a % b;
        end
    endfunction

    // Presents one request; the accept edge happens inside this task.
    task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        sgn      = s;
        @(posedge clk);
        #1;
        start    = 1'b0;
        dividend = $urandom;
        divisor  = $urandom;
    endtask

    // Waits (bounded) for done; reports cycles taken and whether busy/outputs behaved meanwhile.
    task automatic wait_done(output int cyc, output bit busy_ok, output bit hold_ok);
        logic [W-1:0] q0, r0;
        logic         z0;
        q0 = quotient;
        r0 = remainder;
        z0 = div0;
        cyc = -1;
        busy_ok = 1'b1;
        hold_ok = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                cyc = i;
                break;
            end
            if (!busy) busy_ok = 1'b0;
            if (quotient !== q0 || remainder !== r0 || div0 !== z0) hold_ok = 1'b0;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({busy, done, div0, quotient, remainder} !== {3'b000, {W{1'b0}}, {W{1'b0}}}) begin
            errors++;
            $display("FAIL reset_state: got busy=%b done=%b div0=%b q=%h r=%h required all zero",
                     busy, done, div0, quotient, remainder);
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic;
        int cyc;
        bit bok, hok;
        launch(8'd100, 8'd7, 1'b0);
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy_at_accept: got %b required 1", busy); end
        wait_done(cyc, bok, hok);
        checks++;
        if (cyc != W) begin errors++; $display("FAIL basic_latency: got %0d required %0d", cyc, W); end
        checks++;
        if (!bok || !hok) begin errors++; $display("FAIL basic_run_phase: busy_ok=%b hold_ok=%b required 1 1", bok, hok); end
        checks++;
        if (quotient !== 8'd14 || remainder !== 8'd2 || div0 !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_result: got q=%0d r=%0d div0=%b busy=%b required q=14 r=2 div0=0 busy=0",
                     quotient, remainder, div0, busy);
        end
        @(posedge clk);
        #1;
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL basic_done_pulse: got done=%b required 0", done); end
    endtask

    task automatic test_div0;
        int cyc;
        bit bok, hok;
        launch(8'd5, 8'd0, 1'b0);
        wait_done(cyc, bok, hok);
        checks++;
        if (cyc != 1) begin errors++; $display("FAIL div0_latency: got %0d required 1", cyc); end
        checks++;
        if (quotient !== 8'hFF || remainder !== 8'h05 || div0 !== 1'b1) begin
            errors++;
            $display("FAIL div0_result: got q=%h r=%h div0=%b required q=ff r=05 div0=1", quotient, remainder, div0);
        end
        launch(8'd255, 8'd1, 1'b0);
        wait_done(cyc, bok, hok);
        checks++;
        if (cyc != W || quotient !== 8'd255 || remainder !== 8'd0 || div0 !== 1'b0) begin
            errors++;
            $display("FAIL div0_recover: got cyc=%0d q=%0d r=%0d div0=%b required cyc=8 q=255 r=0 div0=0",
                     cyc, quotient, remainder, div0);
        end
    endtask

    task automatic test_small;
        int cyc;
        bit bok, hok;
        launch(8'd3, 8'd10, 1'b0);
        wait_done(cyc, bok, hok);
        checks++;
        if (cyc != W || quotient !== 8'd0 || remainder !== 8'd3) begin
            errors++;
            $display("FAIL small_3_10: got cyc=%0d q=%0d r=%0d required cyc=8 q=0 r=3", cyc, quotient, remainder);
        end
        launch(8'd0, 8'd9, 1'b0);
        wait_done(cyc, bok, hok);
        checks++;
        if (cyc != W || quotient !== 8'd0 || remainder !== 8'd0) begin
            errors++;
            $display("FAIL small_0_9: got cyc=%0d q=%0d r=%0d required cyc=8 q=0 r=0", cyc, quotient, remainder);
        end
    endtask

    task automatic test_handshake;
        int cyc;
        bit bok, hok;
        launch(8'd200, 8'd3, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        launch(8'd50, 8'd5, 1'b0);
        wait_done(cyc, bok, hok);
        checks++;
        if (cyc != W - 3 || quotient !== 8'd66 || remainder !== 8'd2 || !hok) begin
            errors++;
            $display("FAIL handshake_ignore: got cyc=%0d q=%0d r=%0d hold=%b required cyc=%0d q=66 r=2 hold=1",
                     cyc, quotient, remainder, hok, W - 3);
        end
        launch(8'd50, 8'd5, 1'b0);
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL handshake_b2b_accept: got busy=%b done=%b required busy=1 done=0", busy, done);
        end
        wait_done(cyc, bok, hok);
        checks++;
        if (cyc != W || quotient !== 8'd10 || remainder !== 8'd0) begin
            errors++;
            $display("FAIL handshake_b2b_result: got cyc=%0d q=%0d r=%0d required cyc=8 q=10 r=0", cyc, quotient, remainder);
        end
    endtask

    task automatic test_reset_mid;
        int pulses;
        launch(8'd100, 8'd7, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checks++;
        if ({busy, done, div0, quotient, remainder} !== {3'b000, {W{1'b0}}, {W{1'b0}}}) begin
            errors++;
            $display("FAIL reset_mid_state: got busy=%b done=%b div0=%b q=%h r=%h required all zero",
                     busy, done, div0, quotient, remainder);
        end
        pulses = 0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (done || busy) pulses++;
        end
        checks++;
        if (pulses != 0) begin errors++; $display("FAIL reset_mid_no_done: got %0d active cycles required 0", pulses); end
    endtask

    task automatic test_random;
        int cyc;
        bit bok, hok;
        logic [W-1:0] a, b, eq, er;
        logic s;
        for (int n = 0; n < 40; n++) begin
            a = W'($urandom);
            b = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
`ifdef DIV_SIGNED_EN
            s = 1'($urandom_range(0, 1));
`else
            s = 1'b0;
`endif
            model(a, b, s, eq, er);
            launch(a, b, s);
            wait_done(cyc, bok, hok);
            checks++;
            if (cyc != ((b == '0) ? 1 : W) || !bok || !hok) begin
                errors++;
                $display("FAIL random_timing: a=%h b=%h s=%b got cyc=%0d busy_ok=%b hold_ok=%b required cyc=%0d 1 1",
                         a, b, s, cyc, bok, hok, (b == '0) ? 1 : W);
            end
            checks++;
            if (quotient !== eq || remainder !== er || div0 !== (b == '0)) begin
                errors++;
                $display("FAIL random_result: a=%h b=%h s=%b got q=%h r=%h div0=%b required q=%h r=%h div0=%b",
                         a, b, s, quotient, remainder, div0, eq, er, (b == '0));
            end
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end
    endtask

`ifdef DIV_SIGNED_EN
    task automatic test_signed;
        int cyc;
        bit bok, hok;
        logic [W-1:0] av [3] = '{8'hF9, 8'h07, 8'h80};
        logic [W-1:0] bv [3] = '{8'h02, 8'hFE, 8'hFF};
        logic [W-1:0] qv [3] = '{8'hFD, 8'hFD, 8'h80};
        logic [W-1:0] rv [3] = '{8'hFF, 8'h01, 8'h00};
        for (int i = 0; i < 3; i++) begin
            launch(av[i], bv[i], 1'b1);
            wait_done(cyc, bok, hok);
            checks++;
            if (cyc != W || quotient !== qv[i] || remainder !== rv[i] || div0 !== 1'b0) begin
                errors++;
                $display("FAIL signed_%0d: got cyc=%0d q=%h r=%h div0=%b required cyc=8 q=%h r=%h div0=0",
                         i, cyc, quotient, remainder, div0, qv[i], rv[i]);
            end
        end
    endtask
`endif

    initial begin
        test_reset;
        test_basic;
        test_div0;
        test_small;
        test_handshake;
        test_reset_mid;
        test_random;
`ifdef DIV_SIGNED_EN
        test_signed;
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
